fetch_decode_stage: RTL and testbench
=====================================

// Module: fetch_decode_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register for the 16-bit term-project CPU.
//  Holds the PC and drives the instruction-memory address. Latches the returned word,
//  splits it into fields, and presents the low immediate field to the downstream
//  zero-extend/sign-extend units in decode. Supports stall, flush, branch redirect and halt.
// PARAMETERS
//  IMM_W     7        width of immediate field handed to the extend unit (id_imm = instr[IMM_W-1:0])
//  PC_INC    2        PC step per sequential fetch (byte address, 16-bit words)
//  RESET_PC  16'h0000 PC value after reset
//  HALT_OP   4'hF     opcode that freezes fetch
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  stall          in   1      hazard stall: hold PC and IF/ID contents
//  flush          in   1      squash instruction currently being fetched
//  branch_taken   in   1      redirect from EX; implies flush
//  branch_target  in   16     redirect PC
//  imem_addr      out  16     instruction-memory address (= PC register)
//  imem_data      in   16     instruction word, combinational read of imem_addr
//  id_valid       out  1      IF/ID slot holds a real instruction
//  id_pc          out  16     PC of instruction in IF/ID
//  id_instr       out  16     latched instruction (16'h0000 = NOP when bubbled)
//  id_opcode      out  4      id_instr[15:12]
//  id_rs          out  4      id_instr[11:8]
//  id_rt          out  4      id_instr[7:4]
//  id_imm         out  IMM_W  id_instr[IMM_W-1:0], feeds zero-extend unit
//  halted         out  1      fetch frozen by HALT_OP
// BEHAVIOUR
//  - Reset (async, rst_n=0): PC=RESET_PC, id_valid=0, id_pc=0, id_instr=0, halted=0, state=BOOT.
//    Any cycle; in-flight instruction is discarded.
//  - FSM: BOOT -> RUN (first clock after reset release, IF/ID stays a bubble);
//    RUN -> HALTED when a valid HALT_OP is latched into IF/ID;
//    HALTED -> RUN only on branch_taken; otherwise left only by reset.
//  - Per-edge priority in RUN: branch_taken > flush > stall > normal.
//    branch_taken: PC<=branch_target; IF/ID<=bubble (id_valid=0, id_instr=0).
//    flush: PC<=PC+PC_INC; IF/ID<=bubble.
//    stall: PC and IF/ID hold, including id_valid.
//    normal: IF/ID<={1,PC,imem_data}; PC<=PC+PC_INC.
//  - Latency: a word at imem_addr appears on id_* one clock later.
//  - HALTED: PC holds; IF/ID keeps the halt instruction for exactly one cycle, then bubbles.
//    stall/flush are ignored. branch_taken (older branch resolving) wins: PC<=target,
//    IF/ID bubble, halted<=0, state<=RUN.
//  - PC arithmetic is 16-bit modulo: 16'hFFFE+2 -> 16'h0000, with no flag.
//  - Field outputs are pure slices of id_instr, so a bubble yields all-zero fields.
//  - halted is registered and asserts on the same edge that latches HALT_OP.
// STRUCTURE
//  - Shared package/include (cpu_defs): opcode localparams (incl. HALT_OP, NOP=16'h0000),
//    field bit positions, WORD_W=16, FSM state encodings (BOOT, RUN, HALTED).
//  - One sub-module: pc_reg (PC register with load/hold/increment and priority mux).
//  - IF/ID register and FSM live in the top of this file.
// TESTING
//  1 Reset release, imem returns 16'h1234 at 0, 16'h5678 at 2 -> imem_addr 0,2,4;
//    id_instr=16'h1234 (id_valid=1, id_pc=0) one cycle after BOOT; id_imm=7'h34.
//  2 stall held 3 cycles while id_instr=16'h5678 -> imem_addr and id_* frozen, id_valid=1;
//    sequence resumes on release.
//  3 branch_taken with branch_target=16'h0040, stall also high -> next imem_addr=16'h0040,
//    id_valid=0, id_instr=0.
//  4 PC at 16'hFFFE, normal fetch -> imem_addr wraps to 16'h0000; id_pc=16'hFFFE.
//  5 HALT_OP word 16'hF000 fetched -> halted=1, imem_addr frozen, id_valid=0 from the next
//    cycle; later branch_taken to 16'h0010 -> halted=0, fetch resumes at 16'h0010.
//  6 rst_n pulsed low mid-cycle during run -> outputs clear immediately, without waiting for
//    clk; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode stage: word width, field positions,
// opcodes and FSM state encodings.
package fetch_decode_stage_pkg;

    localparam int unsigned WORD_W = 16;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RS_MSB  = 11;
    localparam int unsigned RS_LSB  = 8;
    localparam int unsigned RT_MSB  = 7;
    localparam int unsigned RT_LSB  = 4;

    localparam logic [3:0]        OP_HALT = 4'hF;
    localparam logic [WORD_W-1:0] NOP     = 16'h0000;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/fetch_decode_stage_pc_reg.sv
// Program counter with priority load > increment > hold, 16-bit modulo arithmetic.
module fetch_decode_stage_pc_reg
    import fetch_decode_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_INC   = 16'd2,
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [WORD_W-1:0] i_target,
    output logic [WORD_W-1:0] o_pc
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (i_load) begin
            w_pc_next = i_target;
        end else if (i_inc) begin
            w_pc_next = r_pc + PC_INC;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch plus IF/ID pipeline register with stall, flush, branch redirect
// and halt handling.
module fetch_decode_stage
    import fetch_decode_stage_pkg::*;
#(
    parameter int unsigned       IMM_W    = 7,
    parameter logic [WORD_W-1:0] PC_INC   = 16'd2,
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter logic [3:0]        HALT_OP  = OP_HALT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_branch_taken,
    input  logic [WORD_W-1:0] i_branch_target,
    output logic [WORD_W-1:0] o_imem_addr,
    input  logic [WORD_W-1:0] i_imem_data,
    output logic              o_id_valid,
    output logic [WORD_W-1:0] o_id_pc,
    output logic [WORD_W-1:0] o_id_instr,
    output logic [3:0]        o_id_opcode,
    output logic [3:0]        o_id_rs,
    output logic [3:0]        o_id_rt,
    output logic [IMM_W-1:0]  o_id_imm,
    output logic              o_halted
);

    logic [1:0]        r_state;
    logic              r_id_valid;
    logic [WORD_W-1:0] r_id_pc;
    logic [WORD_W-1:0] r_id_instr;

    logic [1:0]        w_state_d;
    logic              w_id_valid_d;
    logic [WORD_W-1:0] w_id_pc_d;
    logic [WORD_W-1:0] w_id_instr_d;
    logic              w_pc_load;
    logic              w_pc_inc;
    logic [WORD_W-1:0] w_pc;

    fetch_decode_stage_pc_reg #(
        .PC_INC   (PC_INC),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_pc_load),
        .i_inc    (w_pc_inc),
        .i_target (i_branch_target),
        .o_pc     (w_pc)
    );

    always_comb begin
        w_state_d    = r_state;
        w_id_valid_d = r_id_valid;
        w_id_pc_d    = r_id_pc;
        w_id_instr_d = r_id_instr;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_d    = ST_RUN;
                w_id_valid_d = 1'b0;
                w_id_instr_d = NOP;
            end
            ST_RUN: begin
                if (i_branch_taken) begin
                    w_pc_load    = 1'b1;
                    w_id_valid_d = 1'b0;
                    w_id_instr_d = NOP;
                end else if (i_flush) begin
                    w_pc_inc     = 1'b1;
                    w_id_valid_d = 1'b0;
                    w_id_instr_d = NOP;
                end else if (!i_stall) begin
                    w_pc_inc     = 1'b1;
                    w_id_valid_d = 1'b1;
                    w_id_pc_d    = w_pc;
                    w_id_instr_d = i_imem_data;
                    if (i_imem_data[OPC_MSB:OPC_LSB] == HALT_OP) begin
                        w_state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                // Halt word lives in IF/ID for one cycle only; only an older branch revives fetch.
                w_id_valid_d = 1'b0;
                w_id_instr_d = NOP;
                if (i_branch_taken) begin
                    w_pc_load = 1'b1;
                    w_state_d = ST_RUN;
                end
            end
            default: begin
                w_state_d    = ST_BOOT;
                w_id_valid_d = 1'b0;
                w_id_instr_d = NOP;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_BOOT;
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_instr <= NOP;
        end else begin
            r_state    <= w_state_d;
            r_id_valid <= w_id_valid_d;
            r_id_pc    <= w_id_pc_d;
            r_id_instr <= w_id_instr_d;
        end
    end

    assign o_imem_addr = w_pc;
    assign o_id_valid  = r_id_valid;
    assign o_id_pc     = r_id_pc;
    assign o_id_instr  = r_id_instr;
    assign o_id_opcode = r_id_instr[OPC_MSB:OPC_LSB];
    assign o_id_rs     = r_id_instr[RS_MSB:RS_LSB];
    assign o_id_rt     = r_id_instr[RT_MSB:RT_LSB];
    assign o_id_imm    = r_id_instr[IMM_W-1:0];
    assign o_halted    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed self-checking bench for fetch_decode_stage.
module tb_fetch_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [15:0] id_instr;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic [6:0]  id_imm;
    logic        halted;

    logic [15:0] mem [0:32767];
    int          n_vec;
    int          n_err;

    assign imem_data = mem[imem_addr[15:1]];

    fetch_decode_stage dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_imem_addr     (imem_addr),
        .i_imem_data     (imem_data),
        .o_id_valid      (id_valid),
        .o_id_pc         (id_pc),
        .o_id_instr      (id_instr),
        .o_id_opcode     (id_opcode),
        .o_id_rs         (id_rs),
        .o_id_rt         (id_rt),
        .o_id_imm        (id_imm),
        .o_halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({imem_addr, id_valid, id_pc, id_instr, halted} !== {16'h0000, 1'b0, 16'h0, 16'h0, 1'b0})
        begin
            n_err++;
            $display("FAIL reset: got addr=%h v=%b pc=%h instr=%h halt=%b, want 0000 0 0000 0000 0",
                     imem_addr, id_valid, id_pc, id_instr, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({imem_addr, id_valid, id_instr} !== {16'h0000, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL boot: got addr=%h v=%b instr=%h, want 0000 0 0000",
                     imem_addr, id_valid, id_instr);
        end
    endtask

    task automatic test_fetch();
        tick();
        n_vec++;
        if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 16'h0000, 16'h1234, 16'h0002}) begin
            n_err++;
            $display("FAIL fetch0: got v=%b pc=%h instr=%h addr=%h, want 1 0000 1234 0002",
                     id_valid, id_pc, id_instr, imem_addr);
        end
        n_vec++;
        if ({id_opcode, id_rs, id_rt, id_imm} !== {4'h1, 4'h2, 4'h3, 7'h34}) begin
            n_err++;
            $display("FAIL fields0: got op=%h rs=%h rt=%h imm=%h, want 1 2 3 34",
                     id_opcode, id_rs, id_rt, id_imm);
        end
        tick();
        n_vec++;
        if ({id_valid, id_pc, id_instr, imem_addr, id_imm} !==
            {1'b1, 16'h0002, 16'h5678, 16'h0004, 7'h78}) begin
            n_err++;
            $display("FAIL fetch1: got v=%b pc=%h instr=%h addr=%h imm=%h, want 1 0002 5678 0004 78",
                     id_valid, id_pc, id_instr, imem_addr, id_imm);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 16'h0002, 16'h5678, 16'h0004})
            begin
                n_err++;
                $display("FAIL stall%0d: got v=%b pc=%h instr=%h addr=%h, want 1 0002 5678 0004",
                         i, id_valid, id_pc, id_instr, imem_addr);
            end
        end
        stall = 1'b0;
        tick();
        n_vec++;
        if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 16'h0004, 16'h9ABC, 16'h0006}) begin
            n_err++;
            $display("FAIL stall_release: got v=%b pc=%h instr=%h addr=%h, want 1 0004 9abc 0006",
                     id_valid, id_pc, id_instr, imem_addr);
        end
    endtask

    task automatic test_branch_flush();
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        stall         = 1'b1;
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        n_vec++;
        if ({imem_addr, id_valid, id_instr, id_opcode} !== {16'h0040, 1'b0, 16'h0000, 4'h0}) begin
            n_err++;
            $display("FAIL branch: got addr=%h v=%b instr=%h op=%h, want 0040 0 0000 0",
                     imem_addr, id_valid, id_instr, id_opcode);
        end
        tick();
        n_vec++;
        if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 16'h0040, 16'h2345, 16'h0042}) begin
            n_err++;
            $display("FAIL after_branch: got v=%b pc=%h instr=%h addr=%h, want 1 0040 2345 0042",
                     id_valid, id_pc, id_instr, imem_addr);
        end
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        n_vec++;
        if ({id_valid, id_instr, imem_addr} !== {1'b0, 16'h0000, 16'h0044}) begin
            n_err++;
            $display("FAIL flush: got v=%b instr=%h addr=%h, want 0 0000 0044",
                     id_valid, id_instr, imem_addr);
        end
    endtask

    task automatic test_wrap();
        branch_taken  = 1'b1;
        branch_target = 16'hFFFE;
        tick();
        branch_taken = 1'b0;
        tick();
        n_vec++;
        if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 16'hFFFE, 16'h3456, 16'h0000}) begin
            n_err++;
            $display("FAIL wrap: got v=%b pc=%h instr=%h addr=%h, want 1 fffe 3456 0000",
                     id_valid, id_pc, id_instr, imem_addr);
        end
        tick();
        n_vec++;
        if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 16'h0000, 16'h1234, 16'h0002}) begin
            n_err++;
            $display("FAIL after_wrap: got v=%b pc=%h instr=%h addr=%h, want 1 0000 1234 0002",
                     id_valid, id_pc, id_instr, imem_addr);
        end
    endtask

    task automatic test_halt();
        branch_taken  = 1'b1;
        branch_target = 16'h0080;
        tick();
        branch_taken = 1'b0;
        tick();
        n_vec++;
        if ({halted, id_valid, id_pc, id_instr, imem_addr} !==
            {1'b1, 1'b1, 16'h0080, 16'hF000, 16'h0082}) begin
            n_err++;
            $display("FAIL halt_latch: got h=%b v=%b pc=%h instr=%h addr=%h, want 1 1 0080 f000 0082",
                     halted, id_valid, id_pc, id_instr, imem_addr);
        end
        flush = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({halted, id_valid, id_instr, imem_addr} !== {1'b1, 1'b0, 16'h0000, 16'h0082}) begin
                n_err++;
                $display("FAIL halted%0d: got h=%b v=%b instr=%h addr=%h, want 1 0 0000 0082",
                         i, halted, id_valid, id_instr, imem_addr);
            end
        end
        flush         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h0010;
        tick();
        branch_taken = 1'b0;
        n_vec++;
        if ({halted, id_valid, imem_addr} !== {1'b0, 1'b0, 16'h0010}) begin
            n_err++;
            $display("FAIL unhalt: got h=%b v=%b addr=%h, want 0 0 0010",
                     halted, id_valid, imem_addr);
        end
        tick();
        n_vec++;
        if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 16'h0010, 16'h4567, 16'h0012}) begin
            n_err++;
            $display("FAIL resume: got v=%b pc=%h instr=%h addr=%h, want 1 0010 4567 0012",
                     id_valid, id_pc, id_instr, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({imem_addr, id_valid, id_pc, id_instr, halted} !== {16'h0000, 1'b0, 16'h0, 16'h0, 1'b0})
        begin
            n_err++;
            $display("FAIL async_reset: got addr=%h v=%b pc=%h instr=%h h=%b, want 0000 0 0000 0000 0",
                     imem_addr, id_valid, id_pc, id_instr, halted);
        end
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 16'h0000, 16'h1234, 16'h0002}) begin
            n_err++;
            $display("FAIL restart: got v=%b pc=%h instr=%h addr=%h, want 1 0000 1234 0002",
                     id_valid, id_pc, id_instr, imem_addr);
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[16'h0000 >> 1] = 16'h1234;
        mem[16'h0002 >> 1] = 16'h5678;
        mem[16'h0004 >> 1] = 16'h9ABC;
        mem[16'h0040 >> 1] = 16'h2345;
        mem[16'hFFFE >> 1] = 16'h3456;
        mem[16'h0080 >> 1] = 16'hF000;
        mem[16'h0010 >> 1] = 16'h4567;

        test_reset();
        test_fetch();
        test_stall();
        test_branch_flush();
        test_wrap();
        test_halt();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
